// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_unit
//  Description : Sequential ALU. Single-cycle add/sub/logic/shift/slt ops,
//                plus a signed shift-add multiplier and a signed restoring
//                divider, each producing one bit per cycle over WIDTH cycles.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                in_valid/in_ready - request handshake (ready only in IDLE)
//                alu_op, funct     - operation select / R-type function
//                a, b, shamt       - operands and shift amount
//                out_valid         - one-cycle completion pulse
//                result, hi, lo    - result and multiply/divide registers
//                zero              - result == 0
//                illegal           - completed op was not recognised
//                div_by_zero       - completed op was a divide by zero
//                lw_signal         - combinational, alu_op == 00
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             illegal,
    output logic             div_by_zero,
    output logic             lw_signal
);

    localparam logic [1:0]     c_ST_IDLE = 2'd0;
    localparam logic [1:0]     c_ST_MUL  = 2'd1;
    localparam logic [1:0]     c_ST_DIV  = 2'd2;
    localparam logic [SHW-1:0] c_LAST    = SHW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [SHW-1:0]     r_count;
    // Multiply: {partial product high half, remaining multiplier bits}.
    // Divide  : {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;   // multiplicand or divisor magnitude
    logic               r_neg;       // negate product / quotient at the end
    logic               r_rneg;      // negate remainder at the end
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_zero;
    logic               r_out_valid;
    logic               r_illegal;
    logic               r_dbz;

    // ------------------------------------------------------------------
    // Operation decode
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_single_res;
    logic             w_is_mult;
    logic             w_is_div;
    logic             w_is_illegal;

    always_comb begin
        w_single_res = '0;
        w_is_mult    = 1'b0;
        w_is_div     = 1'b0;
        w_is_illegal = 1'b0;
        case (alu_op)
            2'b00: w_single_res = a + b;
            2'b01: w_single_res = a - b;
            2'b10: begin
                case (funct)
                    6'b100000: w_single_res = a + b;
                    6'b100010: w_single_res = a - b;
                    6'b100100: w_single_res = a & b;
                    6'b100101: w_single_res = a | b;
                    6'b100110: w_single_res = a ^ b;
                    6'b101010: w_single_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
                    6'b000000: w_single_res = b << shamt;
                    6'b000010: w_single_res = b >> shamt;
                    6'b011000: w_is_mult    = 1'b1;
                    6'b011010: w_is_div     = 1'b1;
                    default:   w_is_illegal = 1'b1;
                endcase
            end
            default: w_is_illegal = 1'b1;
        endcase
    end

    // Both iterative engines work on magnitudes; signs are reapplied at
    // completion. The most-negative value's magnitude still fits unsigned.
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    assign w_a_mag = a[WIDTH-1] ? -a : a;
    assign w_b_mag = b[WIDTH-1] ? -b : b;

    // ------------------------------------------------------------------
    // Shift-add multiply step
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_prod;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_operand} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg ? -w_mul_next : w_mul_next;

    // ------------------------------------------------------------------
    // Restoring divide step. The partial remainder stays below the
    // divisor, so the borrow bit of the trial subtraction is a reliable
    // "shifted remainder < divisor" indicator.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_operand};
    assign w_div_ge    = ~w_div_diff[WIDTH];
    assign w_div_rem   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_next  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};
    assign w_quo       = r_neg  ? -w_div_next[WIDTH-1:0]       : w_div_next[WIDTH-1:0];
    assign w_rem       = r_rneg ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // Control and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_count     <= '0;
            r_acc       <= '0;
            r_operand   <= '0;
            r_neg       <= 1'b0;
            r_rneg      <= 1'b0;
            r_result    <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        if (w_is_illegal) begin
                            r_out_valid <= 1'b1;
                            r_illegal   <= 1'b1;
                            r_dbz       <= 1'b0;
                        end else if (w_is_mult) begin
                            r_state   <= c_ST_MUL;
                            r_count   <= '0;
                            r_acc     <= {{WIDTH{1'b0}}, w_b_mag};
                            r_operand <= w_a_mag;
                            r_neg     <= a[WIDTH-1] ^ b[WIDTH-1];
                        end else if (w_is_div) begin
                            if (b == '0) begin
                                // Divide by zero completes immediately.
                                r_hi        <= a;
                                r_lo        <= '1;
                                r_result    <= '1;
                                r_zero      <= 1'b0;
                                r_out_valid <= 1'b1;
                                r_illegal   <= 1'b0;
                                r_dbz       <= 1'b1;
                            end else begin
                                r_state   <= c_ST_DIV;
                                r_count   <= '0;
                                r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
                                r_operand <= w_b_mag;
                                r_neg     <= a[WIDTH-1] ^ b[WIDTH-1];
                                r_rneg    <= a[WIDTH-1];
                            end
                        end else begin
                            r_result    <= w_single_res;
                            r_zero      <= (w_single_res == '0);
                            r_out_valid <= 1'b1;
                            r_illegal   <= 1'b0;
                            r_dbz       <= 1'b0;
                        end
                    end
                end
                c_ST_MUL: begin
                    r_acc <= w_mul_next;
                    if (r_count == c_LAST) begin
                        r_state     <= c_ST_IDLE;
                        r_count     <= '0;
                        r_hi        <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo        <= w_prod[WIDTH-1:0];
                        r_result    <= w_prod[WIDTH-1:0];
                        r_zero      <= (w_prod[WIDTH-1:0] == '0);
                        r_out_valid <= 1'b1;
                        r_illegal   <= 1'b0;
                        r_dbz       <= 1'b0;
                    end else begin
                        r_count <= r_count + SHW'(1);
                    end
                end
                c_ST_DIV: begin
                    r_acc <= w_div_next;
                    if (r_count == c_LAST) begin
                        r_state     <= c_ST_IDLE;
                        r_count     <= '0;
                        r_hi        <= w_rem;
                        r_lo        <= w_quo;
                        r_result    <= w_quo;
                        r_zero      <= (w_quo == '0);
                        r_out_valid <= 1'b1;
                        r_illegal   <= 1'b0;
                        r_dbz       <= 1'b0;
                    end else begin
                        r_count <= r_count + SHW'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == c_ST_IDLE);
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign zero        = r_zero;
    assign illegal     = r_illegal;
    assign div_by_zero = r_dbz;
    assign lw_signal   = (alu_op == 2'b00);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_unit
//  Description : Directed self-checking bench for alu_seq_unit (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_unit;

    localparam int c_width = 32;
    localparam int c_shw   = 5;

    logic               r_clk = 1'b0;
    logic               r_rst;
    logic               r_in_valid;
    logic [1:0]         r_alu_op;
    logic [5:0]         r_funct;
    logic [c_width-1:0] r_a;
    logic [c_width-1:0] r_b;
    logic [c_shw-1:0]   r_shamt;

    logic               w_in_ready;
    logic               w_out_valid;
    logic [c_width-1:0] w_result;
    logic [c_width-1:0] w_hi;
    logic [c_width-1:0] w_lo;
    logic               w_zero;
    logic               w_illegal;
    logic               w_dbz;
    logic               w_lw;

    int n_pass  = 0;
    int n_total = 0;

    alu_seq_unit #(.WIDTH(c_width), .SHW(c_shw)) dut (
        .clk        (r_clk),
        .rst        (r_rst),
        .in_valid   (r_in_valid),
        .in_ready   (w_in_ready),
        .alu_op     (r_alu_op),
        .funct      (r_funct),
        .a          (r_a),
        .b          (r_b),
        .shamt      (r_shamt),
        .out_valid  (w_out_valid),
        .result     (w_result),
        .hi         (w_hi),
        .lo         (w_lo),
        .zero       (w_zero),
        .illegal    (w_illegal),
        .div_by_zero(w_dbz),
        .lw_signal  (w_lw)
    );

    always #5 r_clk = ~r_clk;

    // Presents one request for exactly one rising edge; returns at the
    // falling edge right after the accept edge.
    task automatic drive_op(input logic [1:0] op, input logic [5:0] fn,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sh);
        @(negedge r_clk);
        r_alu_op   = op;
        r_funct    = fn;
        r_a        = a;
        r_b        = b;
        r_shamt    = sh;
        r_in_valid = 1'b1;
        @(negedge r_clk);
        r_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        r_rst = 1'b1; r_in_valid = 1'b0; r_alu_op = 2'b00; r_funct = '0;
        r_a = '0; r_b = '0; r_shamt = '0;
        repeat (2) @(negedge r_clk);
        r_rst = 1'b0;
        n_total++; if (w_result !== 32'h0) $display("FAIL reset_result got %h want 0", w_result); else n_pass++;
        n_total++; if ({w_hi, w_lo} !== 64'h0) $display("FAIL reset_hilo got %h want 0", {w_hi, w_lo}); else n_pass++;
        n_total++; if ({w_zero, w_out_valid, w_illegal, w_dbz, w_in_ready} !== 5'b10001)
            $display("FAIL reset_flags got %b want 10001", {w_zero, w_out_valid, w_illegal, w_dbz, w_in_ready}); else n_pass++;
    endtask

    task automatic test_sub_zero();
        drive_op(2'b10, 6'b100010, 32'd5, 32'd5, 5'd0);
        n_total++; if (w_out_valid !== 1'b1) $display("FAIL sub_zero_valid got %b want 1", w_out_valid); else n_pass++;
        n_total++; if ({w_result, w_zero} !== {32'h0, 1'b1}) $display("FAIL sub_zero_res got %h/%b want 0/1", w_result, w_zero); else n_pass++;
        @(negedge r_clk);
        n_total++; if (w_out_valid !== 1'b0) $display("FAIL sub_zero_pulse got %b want 0", w_out_valid); else n_pass++;
    endtask

    logic [1:0]  v_op  [8] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0]  v_fn  [8] = '{6'h00, 6'h00, 6'b100000, 6'b100100, 6'b100101, 6'b100110, 6'b000010, 6'b101010};
    logic [31:0] v_a   [8] = '{32'h10, 32'd3, 32'hFFFFFFFF, 32'hF0F01234, 32'hF0000000, 32'hFFFF0000, 32'h0, 32'd1};
    logic [31:0] v_b   [8] = '{32'h20, 32'd5, 32'd1, 32'h0FF0FF00, 32'h0000000F, 32'h0F0F0F0F, 32'h80000000, 32'hFFFFFFFF};
    logic [4:0]  v_sh  [8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0};
    logic [31:0] v_exp [8] = '{32'h30, 32'hFFFFFFFE, 32'h0, 32'h00F01200, 32'hF000000F, 32'hF0F00F0F, 32'h08000000, 32'h0};

    task automatic test_alu_ops();
        for (int i = 0; i < 8; i++) begin
            @(negedge r_clk);
            r_alu_op = v_op[i]; r_funct = v_fn[i]; r_a = v_a[i]; r_b = v_b[i];
            r_shamt = v_sh[i]; r_in_valid = 1'b1;
            #1;
            n_total++; if (w_lw !== (v_op[i] == 2'b00)) $display("FAIL lw_signal[%0d] got %b want %b", i, w_lw, v_op[i] == 2'b00); else n_pass++;
            @(negedge r_clk);
            r_in_valid = 1'b0;
            n_total++; if ({w_out_valid, w_result} !== {1'b1, v_exp[i]})
                $display("FAIL alu_op[%0d] got valid=%b res=%h want valid=1 res=%h", i, w_out_valid, w_result, v_exp[i]); else n_pass++;
        end
        n_total++; if ({w_hi, w_lo} !== 64'h0) $display("FAIL single_hilo got %h want 0", {w_hi, w_lo}); else n_pass++;
    endtask

    task automatic test_sll_slt();
        drive_op(2'b10, 6'b000000, 32'h0, 32'd1, 5'd31);
        n_total++; if (w_result !== 32'h80000000) $display("FAIL sll got %h want 80000000", w_result); else n_pass++;
        drive_op(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 5'd0);
        n_total++; if ({w_result, w_zero} !== {32'd1, 1'b0}) $display("FAIL slt got %h/%b want 1/0", w_result, w_zero); else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge r_clk);
        r_alu_op = 2'b00; r_a = 32'd1; r_b = 32'd2; r_in_valid = 1'b1;
        @(negedge r_clk);
        n_total++; if ({w_out_valid, w_result, w_in_ready} !== {1'b1, 32'd3, 1'b1}) $display("FAIL b2b_0 got %b/%h want 1/3", w_out_valid, w_result); else n_pass++;
        r_alu_op = 2'b01; r_a = 32'd10; r_b = 32'd4;
        @(negedge r_clk);
        n_total++; if ({w_out_valid, w_result} !== {1'b1, 32'd6}) $display("FAIL b2b_1 got %b/%h want 1/6", w_out_valid, w_result); else n_pass++;
        r_alu_op = 2'b10; r_funct = 6'b100110; r_a = 32'hF; r_b = 32'h3;
        @(negedge r_clk);
        r_in_valid = 1'b0;
        n_total++; if ({w_out_valid, w_result} !== {1'b1, 32'hC}) $display("FAIL b2b_2 got %b/%h want 1/c", w_out_valid, w_result); else n_pass++;
        @(negedge r_clk);
        n_total++; if (w_out_valid !== 1'b0) $display("FAIL b2b_end got %b want 0", w_out_valid); else n_pass++;
    endtask

    // Shared by multiply and divide: accept, scramble the inputs, then
    // measure the busy window and check the completion.
    task automatic test_iter(input string name, input logic [5:0] fn,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy;
        int pulses;
        busy = 0;
        pulses = 0;
        drive_op(2'b10, fn, a, b, 5'd0);
        r_a = 32'h12345678; r_b = 32'h0BADF00D; r_funct = 6'b100000;
        while (w_in_ready === 1'b0 && busy < 100) begin
            if (w_out_valid === 1'b1) pulses++;
            busy++;
            @(negedge r_clk);
        end
        n_total++; if (busy !== 32 || pulses !== 0) $display("FAIL %s_busy got %0d cycles/%0d pulses want 32/0", name, busy, pulses); else n_pass++;
        n_total++; if ({w_out_valid, w_hi, w_lo} !== {1'b1, exp_hi, exp_lo})
            $display("FAIL %s_res got valid=%b hi=%h lo=%h want 1 %h %h", name, w_out_valid, w_hi, w_lo, exp_hi, exp_lo); else n_pass++;
        n_total++; if ({w_result, w_dbz, w_illegal} !== {exp_lo, 2'b00}) $display("FAIL %s_flags got %h/%b%b want %h/00", name, w_result, w_dbz, w_illegal, exp_lo); else n_pass++;
        @(negedge r_clk);
        n_total++; if (w_out_valid !== 1'b0) $display("FAIL %s_pulse got %b want 0", name, w_out_valid); else n_pass++;
    endtask

    task automatic test_div_by_zero();
        drive_op(2'b10, 6'b011010, 32'd9, 32'd0, 5'd0);
        n_total++; if ({w_out_valid, w_in_ready, w_hi, w_lo, w_result} !== {2'b11, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFFF})
            $display("FAIL div0_res got v=%b r=%b hi=%h lo=%h res=%h want 1 1 9 ffffffff ffffffff", w_out_valid, w_in_ready, w_hi, w_lo, w_result); else n_pass++;
        n_total++; if ({w_dbz, w_illegal, w_zero} !== 3'b100) $display("FAIL div0_flags got %b want 100", {w_dbz, w_illegal, w_zero}); else n_pass++;
        @(negedge r_clk);
        n_total++; if ({w_out_valid, w_dbz} !== 2'b01) $display("FAIL div0_hold got %b want 01", {w_out_valid, w_dbz}); else n_pass++;
    endtask

    task automatic test_illegal();
        drive_op(2'b10, 6'b111111, 32'd1, 32'd2, 5'd0);
        n_total++; if ({w_out_valid, w_illegal, w_dbz} !== 3'b110) $display("FAIL illegal_funct_flags got %b want 110", {w_out_valid, w_illegal, w_dbz}); else n_pass++;
        n_total++; if ({w_result, w_hi, w_lo} !== {32'hFFFFFFFF, 32'd9, 32'hFFFFFFFF})
            $display("FAIL illegal_funct_hold got %h %h %h want ffffffff 9 ffffffff", w_result, w_hi, w_lo); else n_pass++;
        drive_op(2'b11, 6'b100000, 32'd1, 32'd2, 5'd0);
        n_total++; if ({w_out_valid, w_illegal, w_result} !== {2'b11, 32'hFFFFFFFF}) $display("FAIL illegal_op got %b%b %h want 11 ffffffff", w_out_valid, w_illegal, w_result); else n_pass++;
    endtask

    task automatic test_reset_mid_mult();
        int pulses;
        pulses = 0;
        drive_op(2'b10, 6'b011000, 32'd5, 32'd6, 5'd0);
        repeat (10) @(negedge r_clk);
        r_rst = 1'b1;
        @(negedge r_clk);
        r_rst = 1'b0;
        n_total++; if ({w_in_ready, w_out_valid} !== 2'b10) $display("FAIL rst_mid_ready got %b want 10", {w_in_ready, w_out_valid}); else n_pass++;
        n_total++; if ({w_hi, w_lo, w_result, w_zero} !== {96'h0, 1'b1}) $display("FAIL rst_mid_regs got %h %h %h %b want 0 0 0 1", w_hi, w_lo, w_result, w_zero); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            if (w_out_valid === 1'b1) pulses++;
            @(negedge r_clk);
        end
        n_total++; if (pulses !== 0) $display("FAIL rst_mid_pulse got %0d pulses want 0", pulses); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sub_zero();
        test_alu_ops();
        test_sll_slt();
        test_back_to_back();
        test_iter("mult_neg", 6'b011000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        test_iter("mult_big", 6'b011000, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000002);
        test_iter("div_neg", 6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_iter("div_negb", 6'b011010, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);
        test_iter("div_minneg", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        test_div_by_zero();
        test_illegal();
        test_reset_mid_mult();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
